// File: rtl/ct_vec_engine_pkg.sv
// Shared types and constants for the ciphertext vector engine.
// Geometry, modulus and plaintext scale are fixed here and used by every file.
// Optional feature macro: CT_PT_ADD_EN (ciphertext-plaintext add with scaling).
package ct_vec_engine_pkg;

    localparam int N_COEFF = 8;                  // coefficients per polynomial
    localparam int LANES   = 4;                  // coefficients per chunk
    localparam int COEFF_W = 32;                 // coefficient width
    localparam int Q       = 97;                 // modulus
    localparam int DELTA   = 10;                 // plaintext scale
    localparam int RADDR_W = 4;                  // register index width
    localparam int NCHUNK  = N_COEFF / LANES;
    localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        OP_CT_CT_ADD = 2'd0,
        OP_CT_CT_SUB = 2'd1,
        OP_CT_PT_ADD = 2'd2
    } mode_e;

    typedef struct packed {
        mode_e              mode;
        logic [RADDR_W-1:0] idx1_a;
        logic [RADDR_W-1:0] idx1_b;
        logic [RADDR_W-1:0] idx2_a;
        logic [RADDR_W-1:0] idx2_b;
        logic [RADDR_W-1:0] out_a;
        logic [RADDR_W-1:0] out_b;
    } operation_t;

    // Per-lane function, decoded from mode and the current pass.
    typedef enum logic [1:0] {
        FN_ADD,
        FN_SUB,
        FN_COPY,
        FN_SCALED_ADD
    } lane_fn_e;

    // True when this build can execute the given mode.
    function automatic logic mode_supported(input mode_e m);
        case (m)
            OP_CT_CT_ADD, OP_CT_CT_SUB: mode_supported = 1'b1;
`ifdef CT_PT_ADD_EN
            OP_CT_PT_ADD:               mode_supported = 1'b1;
`else
            OP_CT_PT_ADD:               mode_supported = 1'b0;
`endif
            default:                    mode_supported = 1'b0;
        endcase
    endfunction

    // (a + b) mod Q for operands already below Q: one conditional subtract.
    function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
        logic [COEFF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (COEFF_W+1)'(Q))
            s = s - (COEFF_W+1)'(Q);
        mod_add = s[COEFF_W-1:0];
    endfunction

    // (a - b) mod Q for operands already below Q: add Q once on borrow.
    function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
        if (a >= b)
            mod_sub = a - b;
        else
            mod_sub = a + (COEFF_W'(Q) - b);
    endfunction

endpackage

// File: rtl/ct_vec_engine_lane.sv
// ct_lane: one coefficient of modular add / sub / copy / scaled add.
// Purely combinational; the engine registers its output.
// With CT_PT_ADD_EN defined the plaintext operand is multiplied by DELTA
// and reduced mod Q before the add; otherwise that datapath is absent.
module ct_lane
    import ct_vec_engine_pkg::*;
(
    input  lane_fn_e fn,
    input  coeff_t   x,
    input  coeff_t   y,
    output coeff_t   z
);

`ifdef CT_PT_ADD_EN
    localparam logic [2*COEFF_W-1:0] DELTA_W = (2*COEFF_W)'(DELTA);
    localparam logic [2*COEFF_W-1:0] Q_W     = (2*COEFF_W)'(Q);

    logic [2*COEFF_W-1:0] prod;
    logic [2*COEFF_W-1:0] prod_mod;
    coeff_t               y_scaled;

    // Constant multiply and constant-modulus reduction of the plaintext.
    assign prod     = {{COEFF_W{1'b0}}, y} * DELTA_W;
    assign prod_mod = prod % Q_W;
    assign y_scaled = prod_mod[COEFF_W-1:0];
`endif

    // Select the lane result for the decoded function.
    // NOTE: combinational blocks assign every output first so no path can infer a latch.
    always_comb begin
        z = x;
        case (fn)
            FN_ADD:        z = mod_add(x, y);
            FN_SUB:        z = mod_sub(x, y);
            FN_COPY:       z = x;
`ifdef CT_PT_ADD_EN
            FN_SCALED_ADD: z = mod_add(x, y_scaled);
`else
            FN_SCALED_ADD: z = x;
`endif
            default:       z = x;
        endcase
    end

endmodule

// File: rtl/ct_vec_engine.sv
// ct_vec_engine: streams two register-file passes through LANES modular lanes.
// Pass A reads idx1_a/idx2_a chunk by chunk and writes out_a; pass B does the
// same for idx1_b/idx2_b into out_b. Each write lands two cycles after its read.
// Optional feature macro: CT_PT_ADD_EN enables OP_CT_PT_ADD; without it that
// mode is rejected like any unknown mode.
module ct_vec_engine
    import ct_vec_engine_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  operation_t               op,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rf_rd_en,
    output logic [RADDR_W-1:0]       rf_rd_addr0,
    output logic [RADDR_W-1:0]       rf_rd_addr1,
    output logic [CHUNK_W-1:0]       rf_rd_chunk,
    input  logic [LANES*COEFF_W-1:0] rf_rd_data0,
    input  logic [LANES*COEFF_W-1:0] rf_rd_data1,
    output logic                     rf_wr_en,
    output logic [RADDR_W-1:0]       rf_wr_addr,
    output logic [CHUNK_W-1:0]       rf_wr_chunk,
    output logic [LANES*COEFF_W-1:0] rf_wr_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PASS_A = 2'd1;
    localparam logic [1:0] PASS_B = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]               state_q;
    logic [CHUNK_W-1:0]       chunk_q;
    operation_t               op_q;
    logic                     done_q;
    logic                     err_q;
    logic                     p1_v_q;        // read data valid this cycle
    logic                     p1_pass_b_q;
    logic [CHUNK_W-1:0]       p1_chunk_q;
    logic                     last_chunk;
    logic                     op_ok;
    lane_fn_e                 lane_fn;
    coeff_t                   lane_out [LANES];
    logic [LANES*COEFF_W-1:0] wr_next;

    assign last_chunk = (chunk_q == CHUNK_W'(NCHUNK - 1));

    // An A-pass write into a B-pass source would corrupt pass B, so reject it.
    assign op_ok = mode_supported(op.mode)
                && (op.out_a != op.idx1_b)
                && (op.out_a != op.idx2_b);

    // Sequencer: accept/reject, walk chunks of both passes, then drain.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            chunk_q <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op_ok) begin
                            op_q    <= op;
                            chunk_q <= '0;
                            state_q <= PASS_A;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                PASS_A: begin
                    if (last_chunk) begin
                        chunk_q <= '0;
                        state_q <= PASS_B;
                    end else begin
                        chunk_q <= chunk_q + CHUNK_W'(1);
                    end
                end
                PASS_B: begin
                    if (last_chunk) begin
                        chunk_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        chunk_q <= chunk_q + CHUNK_W'(1);
                    end
                end
                DRAIN: begin
                    // Last read's data has been consumed; its write is on the port now.
                    if (!p1_v_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rf_rd_en = (state_q == PASS_A) || (state_q == PASS_B);

    // Read request: addresses are driven only while a read is issued.
    always_comb begin
        rf_rd_addr0 = '0;
        rf_rd_addr1 = '0;
        rf_rd_chunk = '0;
        if (state_q == PASS_A) begin
            rf_rd_addr0 = op_q.idx1_a;
            rf_rd_addr1 = op_q.idx2_a;
            rf_rd_chunk = chunk_q;
        end else if (state_q == PASS_B) begin
            rf_rd_addr0 = op_q.idx1_b;
            rf_rd_addr1 = op_q.idx2_b;
            rf_rd_chunk = chunk_q;
        end
    end

    // Lane function for the chunk whose data is arriving this cycle.
    always_comb begin
        lane_fn = FN_ADD;
        case (op_q.mode)
            OP_CT_CT_ADD: lane_fn = FN_ADD;
            OP_CT_CT_SUB: lane_fn = FN_SUB;
            OP_CT_PT_ADD: lane_fn = p1_pass_b_q ? FN_SCALED_ADD : FN_COPY;
            default:      lane_fn = FN_ADD;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ct_lane u_lane (
            .fn (lane_fn),
            .x  (rf_rd_data0[i*COEFF_W +: COEFF_W]),
            .y  (rf_rd_data1[i*COEFF_W +: COEFF_W]),
            .z  (lane_out[i])
        );
        assign wr_next[i*COEFF_W +: COEFF_W] = lane_out[i];
    end

    // Two-stage write pipeline: track read -> register lane results -> write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_v_q      <= 1'b0;
            p1_pass_b_q <= 1'b0;
            p1_chunk_q  <= '0;
            rf_wr_en    <= 1'b0;
            rf_wr_addr  <= '0;
            rf_wr_chunk <= '0;
            rf_wr_data  <= '0;
        end else begin
            p1_v_q      <= rf_rd_en;
            p1_pass_b_q <= (state_q == PASS_B);
            p1_chunk_q  <= chunk_q;
            rf_wr_en    <= p1_v_q;
            if (p1_v_q) begin
                rf_wr_addr  <= p1_pass_b_q ? op_q.out_b : op_q.out_a;
                rf_wr_chunk <= p1_chunk_q;
                rf_wr_data  <= wr_next;
            end else begin
                rf_wr_addr  <= '0;
                rf_wr_chunk <= '0;
                rf_wr_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ct_vec_engine.sv
// Testbench for ct_vec_engine: register-file model, scoreboard of expected
// chunk writes, and a per-coefficient arithmetic reference model.
// Honours CT_PT_ADD_EN the same way the design does.
module tb_ct_vec_engine;
    import ct_vec_engine_pkg::*;

    localparam int NREG = 1 << RADDR_W;
    localparam int DW   = LANES * COEFF_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    operation_t         op_s;
    logic               busy, done, err;
    logic               rf_rd_en;
    logic [RADDR_W-1:0] rf_rd_addr0, rf_rd_addr1;
    logic [CHUNK_W-1:0] rf_rd_chunk;
    logic [DW-1:0]      rf_rd_data0, rf_rd_data1;
    logic               rf_wr_en;
    logic [RADDR_W-1:0] rf_wr_addr;
    logic [CHUNK_W-1:0] rf_wr_chunk;
    logic [DW-1:0]      rf_wr_data;

    ct_vec_engine dut (
        .clk(clk), .reset(reset), .start(start), .op(op_s),
        .busy(busy), .done(done), .err(err),
        .rf_rd_en(rf_rd_en), .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
        .rf_rd_chunk(rf_rd_chunk), .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_chunk(rf_wr_chunk),
        .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register file model (one-cycle read latency), written by DUT or preload.
    int unsigned rf [NREG][N_COEFF];
    logic               pl_en = 1'b0;
    logic [RADDR_W-1:0] pl_addr;
    int unsigned        pl_vals [N_COEFF];

    always @(posedge clk) begin
        if (rf_rd_en) begin
            for (int j = 0; j < LANES; j++) begin
                rf_rd_data0[j*COEFF_W +: COEFF_W] <= rf[rf_rd_addr0][int'(rf_rd_chunk)*LANES + j];
                rf_rd_data1[j*COEFF_W +: COEFF_W] <= rf[rf_rd_addr1][int'(rf_rd_chunk)*LANES + j];
            end
        end else begin
            rf_rd_data0 <= {LANES{$urandom}};
            rf_rd_data1 <= {LANES{$urandom}};
        end
        if (rf_wr_en)
            for (int j = 0; j < LANES; j++)
                rf[rf_wr_addr][int'(rf_wr_chunk)*LANES + j] <= rf_wr_data[j*COEFF_W +: COEFF_W];
        if (pl_en)
            for (int j = 0; j < N_COEFF; j++)
                rf[pl_addr][j] <= pl_vals[j];
    end

    // Scoreboard of expected writes, each with its absolute cycle.
    typedef struct {
        logic [RADDR_W-1:0] addr;
        int                 chunk;
        logic [DW-1:0]      data;
        int                 cyc;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    wr_exp_t mon_e;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rf_rd_en) rd_cnt++;
        if (done) done_cnt++;
        if (rf_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", rf_wr_addr, mon_e.addr);
                check("wr_chunk", rf_wr_chunk, mon_e.chunk);
                check("wr_data", rf_wr_data, mon_e.data);
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Reference model.
    int unsigned shadow [NREG][N_COEFF];

    function automatic int unsigned ref_coeff(input int m, input bit pass_b,
                                              input int unsigned x, input int unsigned y);
        int d;
        case (m)
            0: ref_coeff = (x + y) % Q;
            1: begin d = (int'(x) - int'(y)) % Q; ref_coeff = (d + Q) % Q; end
            default: ref_coeff = pass_b ? (x + (y * DELTA) % Q) % Q : x;
        endcase
    endfunction

    function automatic bit ref_legal(input operation_t o);
        bit pt_ok;
`ifdef CT_PT_ADD_EN
        pt_ok = 1'b1;
`else
        pt_ok = 1'b0;
`endif
        ref_legal = (int'(o.mode) <= 1 || (int'(o.mode) == 2 && pt_ok))
                 && o.out_a != o.idx1_b && o.out_a != o.idx2_b;
    endfunction

    function automatic operation_t mk_op(input int m, input int i1a, input int i2a,
                                         input int i1b, input int i2b, input int oa, input int ob);
        operation_t o;
        logic [1:0] mb;
        mb       = 2'(m);
        o.mode   = mode_e'(mb);
        o.idx1_a = RADDR_W'(i1a);
        o.idx2_a = RADDR_W'(i2a);
        o.idx1_b = RADDR_W'(i1b);
        o.idx2_b = RADDR_W'(i2b);
        o.out_a  = RADDR_W'(oa);
        o.out_b  = RADDR_W'(ob);
        return o;
    endfunction

    function automatic int mem_mismatches();
        int n = 0;
        for (int r = 0; r < NREG; r++)
            for (int j = 0; j < N_COEFF; j++)
                if (rf[r][j] != shadow[r][j]) n++;
        return n;
    endfunction

    function automatic int reg_mismatches(input int r, input int unsigned v);
        int n = 0;
        for (int j = 0; j < N_COEFF; j++)
            if (rf[r][j] != v) n++;
        return n;
    endfunction

    task automatic preload(input int r);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = RADDR_W'(r);
        for (int j = 0; j < N_COEFF; j++) pl_vals[j] = shadow[r][j];
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic fill_const(input int r, input int unsigned v);
        for (int j = 0; j < N_COEFF; j++) shadow[r][j] = v;
        preload(r);
    endtask

    task automatic fill_rand(input int r);
        for (int j = 0; j < N_COEFF; j++) shadow[r][j] = $urandom_range(Q - 1, 0);
        preload(r);
    endtask

    // Push the model's expected writes for an accepted op issued at a_cyc.
    task automatic push_expected(input operation_t o, input int a_cyc,
                                 output int unsigned res_a [N_COEFF],
                                 output int unsigned res_b [N_COEFF]);
        wr_exp_t e;
        for (int i = 0; i < N_COEFF; i++) begin
            res_a[i] = ref_coeff(int'(o.mode), 1'b0, shadow[o.idx1_a][i], shadow[o.idx2_a][i]);
            res_b[i] = ref_coeff(int'(o.mode), 1'b1, shadow[o.idx1_b][i], shadow[o.idx2_b][i]);
        end
        for (int k = 0; k < 2 * NCHUNK; k++) begin
            e.chunk = k % NCHUNK;
            e.addr  = (k >= NCHUNK) ? o.out_b : o.out_a;
            e.cyc   = a_cyc + 2 + k;
            e.data  = '0;
            for (int j = 0; j < LANES; j++)
                e.data[j*COEFF_W +: COEFF_W] = (k >= NCHUNK) ? res_b[e.chunk*LANES + j]
                                                             : res_a[e.chunk*LANES + j];
            exp_q.push_back(e);
        end
    endtask

    // Issue one op; hold > 0 keeps start high until that cycle.
    task automatic run_op(input operation_t o, input int hold);
        int unsigned res_a [N_COEFF];
        int unsigned res_b [N_COEFF];
        int a_cyc, w0, r0, dcyc;
        bit legal, got;
        legal = ref_legal(o);
        @(negedge clk);
        op_s  = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_cyc = cyc;
        w0    = wr_cnt;
        r0    = rd_cnt;
        if (legal) push_expected(o, a_cyc, res_a, res_b);
        @(negedge clk);                       // cycle 1
        if (hold == 0) start = 1'b0;
        if (legal) begin
            check("busy_c1", busy, 1);
            check("err_c1", err, 0);
            check("rd_addr0_c1", rf_rd_addr0, o.idx1_a);
            got  = 1'b0;
            dcyc = 0;
            for (int i = 2; i < 40 && !got; i++) begin
                @(negedge clk);
                if (i == hold) start = 1'b0;
                if (done) begin got = 1'b1; dcyc = cyc; end
            end
            start = 1'b0;
            check("done_seen", got, 1);
            check("done_cycle", dcyc - a_cyc + 1, 2 * NCHUNK + 3);
            check("busy_at_done", busy, 0);
            check("write_count", wr_cnt - w0, 2 * NCHUNK);
            check("queue_empty", exp_q.size(), 0);
            for (int i = 0; i < N_COEFF; i++) shadow[o.out_a][i] = res_a[i];
            for (int i = 0; i < N_COEFF; i++) shadow[o.out_b][i] = res_b[i];
            @(negedge clk);
            check("done_one_cycle", done, 0);
            @(negedge clk);
            check("idle_after", busy, 0);
        end else begin
            check("err_c1", err, 1);
            check("busy_c1", busy, 0);
            start = 1'b0;
            repeat (3) @(negedge clk);
            check("rej_reads", rd_cnt - r0, 0);
            check("rej_writes", wr_cnt - w0, 0);
            check("err_pulse", err, 0);
        end
    endtask

    task automatic reset_mid_op();
        operation_t  o;
        int unsigned res_a [N_COEFF];
        int unsigned res_b [N_COEFF];
        int a_cyc, w0, d0;
        fill_const(0, 5); fill_const(1, 10); fill_const(2, 7); fill_const(3, 3);
        fill_const(13, 0); fill_const(14, 0);
        o = mk_op(0, 0, 2, 1, 3, 13, 14);
        @(negedge clk);
        op_s  = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_cyc = cyc;
        w0    = wr_cnt;
        d0    = done_cnt;
        push_expected(o, a_cyc, res_a, res_b);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);            // start of cycle 4
        #2;
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_en", rf_rd_en, 0);
        check("rst_wr_en", rf_wr_en, 0);
        check("rst_wr_data", rf_wr_data, 0);
        check("rst_rd_addr0", rf_rd_addr0, 0);
        exp_q.delete();
        check("writes_before_reset", wr_cnt - w0, 1);
        for (int j = 0; j < LANES; j++) shadow[13][j] = res_a[j];
        repeat (4) @(negedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);
        check("no_writes_in_reset", wr_cnt - w0, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("partial_mem", mem_mismatches(), 0);
        check("partial_chunk0", rf[13][0], 12);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op_s  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_rd_en", rf_rd_en, 0);
        check("reset_wr_en", rf_wr_en, 0);
        check("reset_wr_addr", rf_wr_addr, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic add: 5+7 and 10+3.
        fill_const(0, 5); fill_const(1, 10); fill_const(2, 7); fill_const(3, 3);
        run_op(mk_op(0, 0, 2, 1, 3, 4, 5), 0);
        check("mem4_12", reg_mismatches(4, 12), 0);
        check("mem5_13", reg_mismatches(5, 13), 0);

        // Wrap cases.
        fill_const(0, 90); fill_const(1, 10); fill_const(2, 3); fill_const(3, 7);
        run_op(mk_op(0, 0, 1, 2, 3, 6, 7), 0);
        check("add_wrap_3", reg_mismatches(6, 3), 0);
        run_op(mk_op(1, 2, 3, 3, 3, 8, 9), 0);
        check("sub_neg_93", reg_mismatches(8, 93), 0);
        check("sub_zero_0", reg_mismatches(9, 0), 0);

        // Ciphertext + scaled plaintext.
        fill_const(10, 5); fill_const(11, 10); fill_const(12, 4);
        run_op(mk_op(2, 10, 10, 11, 12, 13, 14), 0);
`ifdef CT_PT_ADD_EN
        check("pt_copy_a", reg_mismatches(13, 5), 0);
        check("pt_b_50", reg_mismatches(14, 50), 0);
`endif
        fill_const(12, 20);
        run_op(mk_op(2, 10, 10, 11, 12, 13, 14), 0);
`ifdef CT_PT_ADD_EN
        check("pt_b_16", reg_mismatches(14, 16), 0);
`endif

        // start held high across an op, illegal hazard, in-place.
        run_op(mk_op(0, 0, 1, 2, 3, 4, 5), 5);
        run_op(mk_op(0, 0, 2, 1, 3, 1, 5), 0);
        run_op(mk_op(3, 0, 2, 1, 3, 4, 5), 0);
        run_op(mk_op(1, 0, 2, 1, 3, 0, 1), 0);

        reset_mid_op();
        run_op(mk_op(0, 0, 2, 1, 3, 4, 5), 0);

        // Randomised ops on a small register window to provoke aliasing.
        for (int t = 0; t < 30; t++) begin
            for (int r = 0; r < 8; r++)
                if ($urandom_range(1, 0) == 1) fill_rand(r);
            run_op(mk_op($urandom_range(3, 0), $urandom_range(7, 0), $urandom_range(7, 0),
                         $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0),
                         $urandom_range(7, 0)), 0);
        end

        @(negedge clk);
        check("final_mem", mem_mismatches(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ct_vec_engine.md
CT_VEC_ENGINE -- requirements
Module: ct_vec_engine

Interface
REQ-001 Parameters SHALL be: N_COEFF, 8, coefficients per polynomial; LANES, 4, coefficients per chunk (divides N_COEFF); COEFF_W, 32, coefficient width; Q, 97, modulus (< 2^(COEFF_W-1)); DELTA, 10, plaintext scale (< Q); RADDR_W, 4, register index width. NCHUNK = N_COEFF/LANES.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low (0 = reset).
REQ-004 start  in  1  accept op when idle.
REQ-005 op  in  operation  mode, idx1_a, idx1_b, idx2_a, idx2_b, out_a, out_b.
REQ-006 busy  out  1  op in flight.
REQ-007 done  out  1  one-cycle pulse on completion.
REQ-008 err  out  1  one-cycle pulse on rejected op.
REQ-009 rf_rd_en  out  1; rf_rd_addr0/1  out  RADDR_W each; rf_rd_chunk  out  clog2(NCHUNK): chunk read request.
REQ-010 rf_rd_data0/1  in  LANES*COEFF_W each: read data, valid exactly one cycle after rf_rd_en.
REQ-011 rf_wr_en  out  1; rf_wr_addr  out  RADDR_W; rf_wr_chunk  out  clog2(NCHUNK); rf_wr_data  out  LANES*COEFF_W: chunk write.

Function
REQ-012 FSM states SHALL be IDLE, PASS_A, PASS_B, DRAIN; start in IDLE latches op and enters PASS_A next cycle.
REQ-013 PASS_A issues NCHUNK reads (idx1_a, idx2_a, chunk 0..NCHUNK-1, one per cycle), then PASS_B the same for idx1_b/idx2_b; DRAIN waits for outstanding writes, then IDLE.
REQ-014 Each chunk's result SHALL be registered and written two cycles after its read (pass A to out_a, pass B to out_b); writes back-to-back, no bubbles.
REQ-015 With start accepted at cycle 0, reads occupy cycles 1..2*NCHUNK, writes 3..2*NCHUNK+2, done pulses at 2*NCHUNK+3 with busy falling the same cycle.
REQ-016 OP_CT_CT_ADD: out = (x+y) mod Q per lane; sum >= Q subtracts Q once.
REQ-017 OP_CT_CT_SUB: out = (x-y) mod Q; negative adds Q once.
REQ-018 OP_CT_PT_ADD: pass A copies idx1_a; pass B = (idx1_b + (pt*DELTA mod Q)) mod Q, pt read via idx2_b.
REQ-019 Operands SHALL be assumed < Q; results always < Q.
REQ-020 start while busy SHALL be ignored (no latch, no err).
REQ-021 Unknown mode, or out_a equal to idx1_b or idx2_b (A-pass write corrupting B-pass read), SHALL pulse err the cycle after start, issue no reads/writes, stay IDLE.
REQ-022 In-place ops (out_a==idx1_a, out_b==idx1_b) SHALL be correct.

Reset
REQ-023 While reset=0: state IDLE; busy, done, err, rf_rd_en, rf_wr_en = 0; addresses/chunks/data = 0.
REQ-024 Reset mid-op SHALL abort immediately: no further writes, no done; earlier chunk writes remain.

Configuration
REQ-025 Macro CT_PT_ADD_EN: defined -> OP_CT_PT_ADD supported with constant modular multiplier; undefined -> multiplier absent, OP_CT_PT_ADD treated as unknown mode (REQ-021).

Structure
REQ-026 operation typedef, mode enum (OP_CT_CT_ADD, OP_CT_CT_SUB, OP_CT_PT_ADD), Q, DELTA, N_COEFF, COEFF_W SHALL reside in the shared types package (types.svh).
REQ-027 One sub-module ct_lane (single-coefficient modular add/sub/scaled-add, combinational) SHALL be instantiated LANES times.

Verification (defaults)
REQ-028 CT-CT ADD, regs 0..3 = 5,10,7,3, out 4/5, start cycle 0 -> mem4 all 12, mem5 all 13, done at cycle 7, exactly 4 writes.
REQ-029 ADD wrap: 90 + 10 -> 3; SUB: 3 - 7 -> 93; SUB 7 - 7 -> 0.
REQ-030 CT-PT ADD (CT_PT_ADD_EN): A=5, B=10, PT=4 -> A 5, B 50; PT=20 -> B 16 (200 mod 97 = 6); without macro -> err pulse, no writes.
REQ-031 start held high across op -> one op only; out_a=idx1_b -> err at cycle 1, rf_wr_en never asserted.
REQ-032 reset=0 at cycle 4 of ADD -> outputs 0 immediately, no done; new op after release completes normally.
